// File: rtl/switch_debouncer.sv
// switch_debouncer
// Conditions raw, asynchronous switch and button pad levels into clean,
// synchronous levels for the downstream LED logic. Each channel is
// double-flop synchronised and then debounced by its own stability counter.
// The block also produces one-cycle rise/fall strobes and a combined
// "anything changed" flag.
//
// Optional feature: define SWITCH_DEBOUNCER_TOGGLE_EN to add a sw_toggle
// output. Each bit flips on every debounced rising edge of its channel,
// which turns a push button into a latched on/off control.

module switch_debouncer #(
  parameter int WIDTH         = 14,
  parameter int STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] sw_toggle
`endif
);

  // A counter of this width holds STABLE_CYCLES-1, the highest value it
  // ever reaches before the accepted level is loaded and it clears.
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] clean_next;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_next;

  // Two-flop synchroniser; nothing sits between the flops so metastability
  // has a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce decision: any sample matching the clean level
  // aborts the count; a full run of differing samples accepts the new level.
  always_comb begin
    cnt_next   = cnt;
    clean_next = sw_clean;
    rise_next  = '0;
    fall_next  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2[i] == sw_clean[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        cnt_next[i]   = '0;
        clean_next[i] = sync2[i];
        rise_next[i]  = sync2[i];
        fall_next[i]  = ~sync2[i];
      end else begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Counters, clean levels and strobes; strobes register at the same edge as
  // the clean level so they line up with the new value for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      sw_clean <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
    end else begin
      cnt      <= cnt_next;
      sw_clean <= clean_next;
      sw_rise  <= rise_next;
      sw_fall  <= fall_next;
    end
  end

  // Single summary flag for consumers that only need to know "something moved".
  assign sw_changed = |(sw_rise | sw_fall);

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  // Latched on/off per channel; flips in the same cycle its rise strobe shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_toggle <= '0;
    end else begin
      sw_toggle <= sw_toggle ^ rise_next;
    end
  end
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
// Self-checking bench for switch_debouncer with STABLE_CYCLES=4. A table of
// hand-derived vectors covers reset and clean steps, hand-written sequences
// cover bounce, glitch, mid-count reset and (with SWITCH_DEBOUNCER_TOGGLE_EN)
// the toggle output, and a random phase compares against a window-based
// reference model.

module tb_switch_debouncer;

  localparam int WIDTH  = 14;
  localparam int STABLE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
  logic [WIDTH-1:0] sw_toggle;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed)
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    ,
    .sw_toggle  (sw_toggle)
`endif
  );

  // Reference model: the last two raw samples stand in for the synchroniser,
  // and a window of the last STABLE synchronised samples decides acceptance:
  // a channel flips when every sample in the window is the opposite level.
  logic [WIDTH-1:0] m_pipe [2];
  logic [WIDTH-1:0] m_win  [STABLE];
  logic [WIDTH-1:0] m_clean;
  logic [WIDTH-1:0] m_rise;
  logic [WIDTH-1:0] m_fall;
  logic [WIDTH-1:0] m_toggle;

  typedef struct {
    logic             r;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  task automatic modelReset();
    m_pipe[0] = '0;
    m_pipe[1] = '0;
    for (int k = 0; k < STABLE; k++) m_win[k] = '0;
    m_clean  = '0;
    m_rise   = '0;
    m_fall   = '0;
    m_toggle = '0;
  endtask

  task automatic modelEdge(input logic r, input logic [WIDTH-1:0] raw);
    logic [WIDTH-1:0] all_hi;
    logic [WIDTH-1:0] all_lo;
    if (r) begin
      modelReset();
    end else begin
      for (int k = STABLE - 1; k > 0; k--) m_win[k] = m_win[k-1];
      m_win[0] = m_pipe[1];
      all_hi = '1;
      all_lo = '1;
      for (int k = 0; k < STABLE; k++) begin
        all_hi = all_hi & m_win[k];
        all_lo = all_lo & ~m_win[k];
      end
      m_rise    = all_hi & ~m_clean;
      m_fall    = all_lo & m_clean;
      m_clean   = m_clean ^ (m_rise | m_fall);
      m_toggle  = m_toggle ^ m_rise;
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = raw;
    end
  endtask

  task automatic checkVal(input string name, input logic [WIDTH-1:0] act,
                          input logic [WIDTH-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output against the reference model.
  task automatic checkOutput();
    checkVal("model_clean", sw_clean, m_clean);
    checkVal("model_rise", sw_rise, m_rise);
    checkVal("model_fall", sw_fall, m_fall);
    checkVal("model_changed", WIDTH'(sw_changed), WIDTH'(|(m_rise | m_fall)));
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    checkVal("model_toggle", sw_toggle, m_toggle);
`endif
  endtask

  // Drive inputs well before the edge, advance one edge, sample #1 after it.
  task automatic applyStimulus(input logic r, input logic [WIDTH-1:0] raw);
    rst    = r;
    sw_raw = raw;
    @(posedge clk);
    modelEdge(r, raw);
    #1;
    checkOutput();
  endtask

  function automatic vec_t mk(input logic r, input logic [WIDTH-1:0] raw,
                              input logic [WIDTH-1:0] clean,
                              input logic [WIDTH-1:0] rise,
                              input logic [WIDTH-1:0] fall, input logic ch);
    vec_t v;
    v.r = r; v.raw = raw; v.clean = clean;
    v.rise = rise; v.fall = fall; v.changed = ch;
    return v;
  endfunction

  initial begin
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_clean;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] flip;
    logic             r;
    int               rise_at;
    int               n_rise;
    int               n_fall;

    rst    = 1'b1;
    sw_raw = '0;
    modelReset();

    // Reset with all switches high, then power-on rise after 6 edges.
    for (int i = 0; i < 3; i++) vecs[i] = mk(1'b1, 14'h3FFF, '0, '0, '0, 1'b0);
    for (int i = 3; i < 8; i++) vecs[i] = mk(1'b0, 14'h3FFF, '0, '0, '0, 1'b0);
    vecs[8]  = mk(1'b0, 14'h3FFF, 14'h3FFF, 14'h3FFF, '0, 1'b1);
    vecs[9]  = mk(1'b0, 14'h3FFF, 14'h3FFF, '0, '0, 1'b0);
    // Clean rising step on bit 0, then clean falling step.
    vecs[10] = mk(1'b1, 14'h0000, '0, '0, '0, 1'b0);
    for (int i = 11; i < 16; i++) vecs[i] = mk(1'b0, 14'h0001, '0, '0, '0, 1'b0);
    vecs[16] = mk(1'b0, 14'h0001, 14'h0001, 14'h0001, '0, 1'b1);
    vecs[17] = mk(1'b0, 14'h0001, 14'h0001, '0, '0, 1'b0);
    for (int i = 18; i < 23; i++) vecs[i] = mk(1'b0, 14'h0000, 14'h0001, '0, '0, 1'b0);
    vecs[23] = mk(1'b0, 14'h0000, '0, '0, 14'h0001, 1'b1);
    vecs[24] = mk(1'b0, 14'h0000, '0, '0, '0, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].r, vecs[i].raw);
      checkVal($sformatf("vec%0d_clean", i), sw_clean, vecs[i].clean);
      checkVal($sformatf("vec%0d_rise", i), sw_rise, vecs[i].rise);
      checkVal($sformatf("vec%0d_fall", i), sw_fall, vecs[i].fall);
      checkVal($sformatf("vec%0d_changed", i), WIDTH'(sw_changed), WIDTH'(vecs[i].changed));
    end

    // Bounce on bit 3: 2-cycle levels must never strobe; settle rises at +5.
    applyStimulus(1'b1, '0);
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, ((k / 2) % 2 == 0) ? 14'h0008 : 14'h0000);
      acc = acc | sw_rise | sw_fall;
    end
    checkVal("bounce_no_strobe", acc, '0);
    rise_at = -1;
    n_rise  = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 14'h0008);
      if (sw_rise[3]) begin
        n_rise++;
        if (rise_at < 0) rise_at = k;
      end
    end
    checkInt("bounce_rise_edge", rise_at, 5);
    checkInt("bounce_rise_count", n_rise, 1);

    // Short glitch on bit 5 (3 cycles) is rejected entirely.
    applyStimulus(1'b1, '0);
    acc       = '0;
    acc_clean = '0;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, (k < 3) ? 14'h0020 : 14'h0000);
      acc       = acc | sw_rise | sw_fall;
      acc_clean = acc_clean | sw_clean;
    end
    checkVal("glitch_no_strobe", acc, '0);
    checkVal("glitch_clean_low", acc_clean, '0);

    // A pulse of exactly STABLE cycles is accepted, then released.
    n_rise = 0;
    n_fall = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b0, (k < STABLE) ? 14'h0020 : 14'h0000);
      if (sw_rise[5]) n_rise++;
      if (sw_fall[5]) n_fall++;
    end
    checkInt("pulse4_rise_count", n_rise, 1);
    checkInt("pulse4_fall_count", n_fall, 1);

    // Reset mid-count on bit 7 discards the partial count.
    applyStimulus(1'b1, '0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 14'h0080);
    applyStimulus(1'b1, 14'h0080);
    rise_at = -1;
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(1'b0, 14'h0080);
      if (sw_rise[7] && rise_at < 0) rise_at = j;
    end
    checkInt("midreset_rise_edge", rise_at, 6);
    checkVal("midreset_clean", sw_clean, 14'h0080);

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
    // Two clean presses of bit 13: toggle goes 0->1->0 on the rise cycles.
    applyStimulus(1'b1, '0);
    n_rise = 0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 14; k++) begin
        applyStimulus(1'b0, (k < 7) ? 14'h2000 : 14'h0000);
        if (sw_rise[13]) begin
          n_rise++;
          checkVal("toggle_on_rise", WIDTH'(sw_toggle[13]), WIDTH'(n_rise % 2));
        end
      end
    end
    checkInt("toggle_rise_count", n_rise, 2);
    checkVal("toggle_final", sw_toggle, '0);
`endif

    // Randomised phase: slowly changing levels with occasional resets.
    applyStimulus(1'b1, '0);
    raw = '0;
    for (int s = 0; s < 400; s++) begin
      flip = '0;
      for (int i = 0; i < WIDTH; i++) flip[i] = ($urandom_range(5) == 0);
      raw = raw ^ flip;
      r   = ($urandom_range(99) == 0);
      applyStimulus(r, raw);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Input-side conditioner for the board switches and buttons that feed the LED logic blocks. It runs in the opposite direction to the LED output path: raw asynchronous pad levels in, clean synchronous levels out. Each bit is double-flop synchronised and debounced with a per-bit stability counter. The block also emits one-cycle rise/fall strobes. Its outputs drive the `in` vectors of downstream combinational LED logic.

Parameters:
WIDTH, 14, number of independent switch/button channels
STABLE_CYCLES, 16, consecutive clk cycles a synchronised level must differ from the clean level before it is accepted; legal range 2..65535
CNT_W, $clog2(STABLE_CYCLES), per-channel counter width (derived localparam, not overridable)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
sw_raw  input  WIDTH  raw asynchronous switch/button levels from pads
sw_clean  output  WIDTH  debounced, synchronous level per channel
sw_rise  output  WIDTH  one-cycle strobe per channel; clean level went 0->1
sw_fall  output  WIDTH  one-cycle strobe per channel; clean level went 1->0
sw_changed  output  1  OR of all sw_rise and sw_fall bits, same cycle

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on posedge clk only.
- Reset (rst=1 at an edge): sync1, sync2, sw_clean, counters, sw_rise, sw_fall, sw_changed all -> 0. Applies mid-count too: any partial count is discarded.
- Synchroniser per bit: sync1 <= sw_raw; sync2 <= sync1. No logic between the flops.
- Per-bit counter cnt[i], priority order:
  1. sync2[i] == sw_clean[i]: cnt <= 0 (bounce aborts the count).
  2. else cnt == STABLE_CYCLES-1: sw_clean[i] <= sync2[i]; cnt <= 0; strobe asserted (see below).
  3. else cnt <= cnt+1.
- Strobes are registered. sw_rise[i]/sw_fall[i] are high for exactly the cycle following the edge at which sw_clean[i] updates, aligned with the new sw_clean value. They are 0 in all other cycles.
- Latency: a clean step on sw_raw first sampled at edge E appears on sw_clean after edge E+STABLE_CYCLES+1. That is 2 sync edges plus STABLE_CYCLES count edges, minus the overlap of the first compare.
- A pulse on sync2 shorter than STABLE_CYCLES cycles never reaches sw_clean and produces no strobe.
- Channels are fully independent. Simultaneous transitions on several bits may strobe in the same cycle; sw_changed is a single bit.
- Switch held high through reset: sw_clean rises STABLE_CYCLES+2 edges after rst deasserts, with a sw_rise strobe. This is intended (power-on state reported as an event).
- Counter never exceeds STABLE_CYCLES-1; no wrap-around possible.

Optional Feature:
Macro SWITCH_DEBOUNCER_TOGGLE_EN.
- Defined: adds output port sw_toggle [WIDTH-1:0], reset 0. Bit i inverts on every cycle where sw_rise[i]=1, turning each push button into a latched on/off.
- Not defined: port and register do not exist; all other behaviour identical.

Test Plan:
- Reset: STABLE_CYCLES=4, sw_raw=14'h3FFF, hold rst 3 cycles -> all outputs 0 during rst. sw_clean=14'h3FFF exactly 6 edges after rst falls, with sw_rise=14'h3FFF for one cycle and sw_changed=1 that cycle.
- Clean step: sw_raw[0] 0->1 held -> sw_clean[0]=1 after edge E+5. sw_rise[0] pulses 1 cycle, sw_fall=0, other bits unchanged.
- Bounce rejection: sw_raw[3] toggles 1,0,1,0 every 2 cycles, then settles to 1 -> no strobe during toggling. Single sw_rise[3] at 5 edges after the final settle sample.
- Short glitch: sw_raw[5]=1 for 3 cycles, then 0 -> sw_clean[5] stays 0; sw_rise and sw_fall stay 0.
- Reset mid-count: sw_raw[7] 0->1, assert rst after 3 edges for 1 cycle, keep sw_raw[7]=1 -> count restarts; sw_clean[7]=1 6 edges after rst deasserts.
- Toggle (macro defined): press/release sw_raw[13] twice with clean steps -> sw_toggle[13] goes 0->1->0, each change aligned with a sw_rise[13] cycle.
